// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: multiplexed seven-segment scan with frame-aligned value commit and leading-zero blanking
module hex_display (
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   always_comb
      case (hex)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
endmodule

module hex_scan_ctrl #(
   parameter int NDIGITS = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   value,
   input  logic                   lzb,
   output logic                   ack,
   output logic [NDIGITS-1:0]     an_n,
   output logic [6:0]             seg
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int DW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
   logic [CW-1:0] cnt, cnt_n;
   logic [DW-1:0] dig, dig_n;
   logic [4*NDIGITS-1:0] disp, disp_n, pend_val;
   logic [NDIGITS-1:0] hz, an_nx;
   logic [3:0] nib;
   logic pend, wrap, bnd, blank, z;
   always_comb begin
      wrap = cnt == CW'(REFRESH_DIV - 1);
      bnd = wrap && dig == DW'(NDIGITS - 1);
      cnt_n = wrap ? '0 : cnt + 1'b1;
      dig_n = !wrap ? dig : bnd ? '0 : dig + 1'b1;
      disp_n = bnd && pend ? pend_val : disp;
      z = 1'b1;
      hz = '0;
      // hz[k]: every nibble at index >= k of the value about to be shown is zero
      for (int k = NDIGITS - 1; k >= 0; k--) begin
         z = z && disp_n[4*k +: 4] == 4'd0;
         hz[k] = z;
      end
      blank = lzb && dig_n != '0 && hz[dig_n];
      an_nx = int'(cnt_n) < DEAD || blank ? '1 : ~(NDIGITS'(1) << dig_n);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         dig <= '0;
         disp <= '0;
         pend_val <= '0;
         pend <= 1'b0;
         ack <= 1'b0;
         an_n <= '1;
      end else begin
         cnt <= cnt_n;
         dig <= dig_n;
         disp <= disp_n;
         pend_val <= load ? value : pend_val;
         pend <= load || (pend && !bnd);
         ack <= bnd && pend;
         an_n <= an_nx;
      end
   assign nib = disp[4*dig +: 4];
   hex_display u_dec (.hex(nib), .seg(seg));
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: scoreboard bench for hex_scan_ctrl with NDIGITS=4, REFRESH_DIV=8, DEAD=2
module tb_hex_scan_ctrl;
   localparam int N = 4, R = 8, D = 2, F = N * R;
   logic clk = 0, rst_n = 1, load = 0, lzb = 0, ack;
   logic [15:0] value = 0;
   logic [3:0] an_n;
   logic [6:0] seg;
   int vectors = 0, errors = 0, acks = 0, pos = 0;
   logic [15:0] q[$];
   logic [15:0] bdisp = 0, bpv = 0;
   logic bpend = 0;

   hex_scan_ctrl #(.NDIGITS(N), .REFRESH_DIV(R), .DEAD(D)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .lzb(lzb),
      .ack(ack), .an_n(an_n), .seg(seg));

   always #5 clk = ~clk;

   function automatic logic [6:0] dec(logic [3:0] h);
      case (h)
         4'h0: return 7'b0111111; 4'h1: return 7'b0000110; 4'h2: return 7'b1011011; 4'h3: return 7'b1001111;
         4'h4: return 7'b1100110; 4'h5: return 7'b1101101; 4'h6: return 7'b1111101; 4'h7: return 7'b0000111;
         4'h8: return 7'b1111111; 4'h9: return 7'b1101111; 4'hA: return 7'b1110111; 4'hB: return 7'b1111100;
         4'hC: return 7'b0111001; 4'hD: return 7'b1011110; 4'hE: return 7'b1111001; default: return 7'b1110001;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(int p, logic [15:0] d);
      logic [15:0] t;
      t = d >> (4 * (p / R));
      return dec(t[3:0]);
   endfunction

   function automatic logic [3:0] exp_an(int p, logic [15:0] d, logic lz);
      int k;
      k = p / R;
      if (p % R < D) return 4'hF;
      if (lz && k > 0 && (d >> (4 * k)) == 16'd0) return 4'hF;
      return ~(4'b0001 << k);
   endfunction

   // bench-side model of commit/pending behaviour, advanced one clock per call
   task automatic tick();
      logic bnd;
      bnd = pos == F - 1;
      if (bnd && bpend) bdisp = bpv;
      if (load) begin
         bpv = value;
         bpend = 1;
      end else if (bnd) bpend = 0;
      @(posedge clk);
      #1;
      pos = (pos + 1) % F;
   endtask

   task automatic goto(int p);
      do tick(); while (pos != p);
   endtask

   task automatic do_load(logic [15:0] v);
      value = v;
      load = 1;
      if (bpend && pos != F - 1) q[$] = v;
      else q.push_back(v);
      tick();
      load = 0;
   endtask

   always @(negedge clk)
      if (rst_n && ack) begin
         logic [15:0] e;
         acks++;
         vectors++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected pos=%0d", pos);
         end else begin
            e = q.pop_front();
            if (seg !== dec(e[3:0]) || pos != 0) begin
               errors++;
               $display("FAIL ack_commit got seg=%h pos=%0d exp seg=%h pos=0", seg, pos, dec(e[3:0]));
            end
         end
      end

   task automatic test_reset();
      #2 rst_n = 0;
      #1;
      vectors += 3;
      if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", an_n); end
      if (seg !== dec(0)) begin errors++; $display("FAIL reset_seg got=%h exp=%h", seg, dec(0)); end
      if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      pos = 0;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 40; i++) begin
         tick();
         vectors += 2;
         if (an_n !== exp_an(pos, bdisp, lzb)) begin errors++; $display("FAIL idle_an pos=%0d got=%b exp=%b", pos, an_n, exp_an(pos, bdisp, lzb)); end
         if (seg !== dec(0)) begin errors++; $display("FAIL idle_seg pos=%0d got=%h exp=%h", pos, seg, dec(0)); end
      end
   endtask

   task automatic test_load();
      logic [3:0] ord [4] = '{4'hF, 4'h5, 4'hA, 4'h3};
      goto(5);
      do_load(16'h3A5F);
      for (int i = 0; i < 58; i++) begin
         tick();
         vectors += 2;
         if (an_n !== exp_an(pos, bdisp, lzb)) begin errors++; $display("FAIL load_an pos=%0d got=%b exp=%b", pos, an_n, exp_an(pos, bdisp, lzb)); end
         if (seg !== exp_seg(pos, bdisp)) begin errors++; $display("FAIL load_seg pos=%0d got=%h exp=%h", pos, seg, exp_seg(pos, bdisp)); end
         if (i >= 26 && pos % R == 4) begin
            vectors++;
            if (seg !== dec(ord[pos / R])) begin errors++; $display("FAIL load_order pos=%0d got=%h exp=%h", pos, seg, dec(ord[pos / R])); end
         end
      end
   endtask

   task automatic test_multi();
      int a0;
      a0 = acks;
      goto(2);  do_load(16'h1111);
      goto(10); do_load(16'h2222);
      goto(20); do_load(16'h3333);
      goto(0);
      for (int i = 0; i < F; i++) begin
         tick();
         vectors += 2;
         if (an_n !== exp_an(pos, bdisp, lzb)) begin errors++; $display("FAIL multi_an pos=%0d got=%b exp=%b", pos, an_n, exp_an(pos, bdisp, lzb)); end
         if (seg !== dec(4'h3)) begin errors++; $display("FAIL multi_seg pos=%0d got=%h exp=%h", pos, seg, dec(4'h3)); end
      end
      vectors++;
      if (acks - a0 != 1) begin errors++; $display("FAIL multi_acks got=%0d exp=1", acks - a0); end
   endtask

   task automatic test_back_to_back();
      int a0;
      a0 = acks;
      goto(10);     do_load(16'h1234);
      goto(F - 1);  do_load(16'h4444);
      for (int i = 0; i < 2 * F; i++) begin
         tick();
         vectors += 2;
         if (an_n !== exp_an(pos, bdisp, lzb)) begin errors++; $display("FAIL b2b_an pos=%0d got=%b exp=%b", pos, an_n, exp_an(pos, bdisp, lzb)); end
         if (seg !== exp_seg(pos, bdisp)) begin errors++; $display("FAIL b2b_seg pos=%0d got=%h exp=%h", pos, seg, exp_seg(pos, bdisp)); end
         if (pos == 12) begin
            vectors++;
            if (seg !== dec(i < F ? 4'h3 : 4'h4)) begin errors++; $display("FAIL b2b_digit1 i=%0d got=%h exp=%h", i, seg, dec(i < F ? 4'h3 : 4'h4)); end
         end
      end
      goto(2);
      vectors++;
      if (acks - a0 != 2) begin errors++; $display("FAIL b2b_acks got=%0d exp=2", acks - a0); end
   endtask

   task automatic test_lzb();
      int lit[4];
      int want[2][4] = '{'{6, 6, 0, 0}, '{6, 0, 0, 0}};
      logic [15:0] vals [2] = '{16'h0070, 16'h0000};
      for (int t = 0; t < 2; t++) begin
         goto(3);
         do_load(vals[t]);
         goto(0);
         lzb = 1;
         lit = '{0, 0, 0, 0};
         for (int i = 0; i < F; i++) begin
            tick();
            vectors++;
            if (an_n !== exp_an(pos, bdisp, lzb)) begin errors++; $display("FAIL lzb_an pos=%0d got=%b exp=%b", pos, an_n, exp_an(pos, bdisp, lzb)); end
            if (an_n != 4'hF) lit[pos / R]++;
         end
         for (int k = 0; k < 4; k++) begin
            vectors++;
            if (lit[k] != want[t][k]) begin errors++; $display("FAIL lzb_lit t=%0d digit=%0d got=%0d exp=%0d", t, k, lit[k], want[t][k]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int a0;
      lzb = 0;
      goto(3);
      do_load(16'h5555);
      goto(13);
      #3 rst_n = 0;
      #1;
      q.delete();
      bpend = 0; bpv = 0; bdisp = 0;
      vectors += 2;
      if (an_n !== 4'hF) begin errors++; $display("FAIL rstmid_an got=%b exp=1111", an_n); end
      if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack got=%b exp=0", ack); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      pos = 0;
      a0 = acks;
      for (int i = 0; i < 2 * F; i++) begin
         tick();
         vectors += 2;
         if (an_n !== exp_an(pos, bdisp, lzb)) begin errors++; $display("FAIL rstmid_scan pos=%0d got=%b exp=%b", pos, an_n, exp_an(pos, bdisp, lzb)); end
         if (seg !== dec(0)) begin errors++; $display("FAIL rstmid_seg pos=%0d got=%h exp=%h", pos, seg, dec(0)); end
      end
      vectors++;
      if (acks != a0) begin errors++; $display("FAIL rstmid_noack got=%0d exp=0", acks - a0); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_load();
      test_multi();
      test_back_to_back();
      test_lzb();
      test_reset_mid();
      vectors++;
      if (q.size() != 0) begin errors++; $display("FAIL missing_ack got=%0d exp=0 outstanding", q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
